// File: rtl/cmd_host_arbiter_if.sv
// Command bus shared by the hosts, the arbiter and the fan-out stage.
// The master side drives sel/rd_wr_n/byte_addr/wdata; the slave side answers with ack/rdata.
interface intf_cmd #(
  parameter int AW = 26,
  parameter int DW = 32
);
  logic          sel;
  logic          rd_wr_n;
  logic [AW-1:0] byte_addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output sel, rd_wr_n, byte_addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  sel, rd_wr_n, byte_addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/cmd_host_arbiter.sv
// Round-robin arbiter sharing one downstream command bus between several hosts.
// Optional macro CMD_ARB_TIMEOUT_RESP_EN: acks the host with P_TIMEOUT_RDATA on timeout.
module cmd_host_arbiter #(
  parameter int NUM_HOSTS              = 3,
  parameter int HOST_ADDRESS_BITS      = 26,
  parameter int HOST_DATA_BITS         = 32,
  parameter int P_CMD_ACK_TIMEOUT_CLKS = 32,
  parameter logic [HOST_DATA_BITS-1:0] P_TIMEOUT_RDATA = 'hDEAD_0ACC
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  intf_cmd.slave               i_cmd [NUM_HOSTS-1:0],
  intf_cmd.master              o_cmd,
  output logic [NUM_HOSTS-1:0] o_req_drop,
  output logic [15:0]          o_timeout_cnt
);
  localparam int AW = HOST_ADDRESS_BITS;
  localparam int DW = HOST_DATA_BITS;
  localparam int IW = $clog2(NUM_HOSTS);
  localparam int GW = IW + 1;
  localparam int CW = (P_CMD_ACK_TIMEOUT_CLKS > 2) ?
                      $clog2(P_CMD_ACK_TIMEOUT_CLKS) : 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT_ACK
  } state_t;

  state_t               r_state;
  state_t               w_state_n;

  logic [NUM_HOSTS-1:0] w_sel;
  logic [NUM_HOSTS-1:0] w_rw;
  logic [AW-1:0]        w_addr   [NUM_HOSTS];
  logic [DW-1:0]        w_wdata  [NUM_HOSTS];

  logic [NUM_HOSTS-1:0] r_pend;
  logic [NUM_HOSTS-1:0] r_drop;
  logic [NUM_HOSTS-1:0] r_hrw;
  logic [AW-1:0]        r_haddr  [NUM_HOSTS];
  logic [DW-1:0]        r_hwdata [NUM_HOSTS];

  logic [NUM_HOSTS-1:0] r_hack;
  logic [DW-1:0]        r_hrdata [NUM_HOSTS];

  logic [IW-1:0]        r_last;
  logic [IW-1:0]        w_gnt;
  logic [GW-1:0]        w_idx;
  logic                 w_found;
  logic                 w_issue;
  logic                 w_ack;
  logic                 w_to;
  logic [CW-1:0]        r_to;
  logic [15:0]          r_tocnt;

  logic                 r_osel;
  logic                 r_orw;
  logic [AW-1:0]        r_oaddr;
  logic [DW-1:0]        r_owdata;

  for (genvar h = 0; h < NUM_HOSTS; h++) begin : g_host
    assign w_sel[h]       = i_cmd[h].sel;
    assign w_rw[h]        = i_cmd[h].rd_wr_n;
    assign w_addr[h]      = i_cmd[h].byte_addr;
    assign w_wdata[h]     = i_cmd[h].wdata;
    assign i_cmd[h].ack   = r_hack[h];
    assign i_cmd[h].rdata = r_hrdata[h];
  end

  assign o_cmd.sel       = r_osel;
  assign o_cmd.rd_wr_n   = r_orw;
  assign o_cmd.byte_addr = r_oaddr;
  assign o_cmd.wdata     = r_owdata;
  assign o_req_drop      = r_drop;
  assign o_timeout_cnt   = r_tocnt;

  // Round-robin pick: first pending host after the last grant, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = r_last;
    w_idx   = '0;
    for (int i = 1; i <= NUM_HOSTS; i++) begin
      w_idx = GW'(r_last) + GW'(i);
      if (w_idx >= GW'(NUM_HOSTS))
        w_idx = w_idx - GW'(NUM_HOSTS);
      if (!w_found && r_pend[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IW-1:0];
      end
    end
  end

  // Next state; an ack beats a timeout in the same cycle.
  always_comb begin
    w_state_n = r_state;
    w_issue   = 1'b0;
    w_ack     = 1'b0;
    w_to      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_issue   = 1'b1;
          w_state_n = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (o_cmd.ack) begin
          w_ack     = 1'b1;
          w_state_n = S_IDLE;
        end else if (r_to == CW'(P_CMD_ACK_TIMEOUT_CLKS - 1)) begin
          w_to      = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) r_state <= S_IDLE;
    else           r_state <= w_state_n;
  end

  // Pending flags and sticky drop flags; capture runs regardless of FSM state.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_pend <= '0;
      r_drop <= '0;
    end else begin
      for (int h = 0; h < NUM_HOSTS; h++) begin
        if (w_sel[h] && !r_pend[h])
          r_pend[h] <= 1'b1;
        else if (w_issue && (w_gnt == IW'(h)))
          r_pend[h] <= 1'b0;
        if (w_sel[h] && r_pend[h])
          r_drop[h] <= 1'b1;
      end
    end
  end

  // Holding registers load only when the host has no request outstanding.
  always_ff @(posedge i_sys_clk) begin
    for (int h = 0; h < NUM_HOSTS; h++) begin
      if (w_sel[h] && !r_pend[h]) begin
        r_hrw[h]    <= w_rw[h];
        r_haddr[h]  <= w_addr[h];
        r_hwdata[h] <= w_wdata[h];
      end
    end
  end

  // Downstream issue: one-cycle sel, fields held until the next grant.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_osel   <= 1'b0;
      r_orw    <= 1'b1;
      r_oaddr  <= '0;
      r_owdata <= '0;
      r_last   <= IW'(NUM_HOSTS - 1);
      r_to     <= '0;
    end else begin
      r_osel <= w_issue;
      if (w_issue) begin
        r_orw    <= r_hrw[w_gnt];
        r_oaddr  <= r_haddr[w_gnt];
        r_owdata <= r_hwdata[w_gnt];
        r_last   <= w_gnt;
        r_to     <= '0;
      end else if (r_state == S_WAIT_ACK) begin
        r_to <= r_to + CW'(1);
      end
    end
  end

  // Host responses and the saturating timeout counter.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_hack  <= '0;
      r_tocnt <= '0;
      for (int h = 0; h < NUM_HOSTS; h++)
        r_hrdata[h] <= '0;
    end else begin
      r_hack <= '0;
      if (w_ack) begin
        r_hack[r_last]   <= 1'b1;
        r_hrdata[r_last] <= o_cmd.rdata;
      end
      if (w_to) begin
        if (r_tocnt != 16'hFFFF)
          r_tocnt <= r_tocnt + 16'd1;
`ifdef CMD_ARB_TIMEOUT_RESP_EN
        r_hack[r_last]   <= 1'b1;
        r_hrdata[r_last] <= P_TIMEOUT_RDATA;
`endif
      end
    end
  end

`ifndef CMD_ARB_TIMEOUT_RESP_EN
  logic [DW-1:0] w_unused_rdata;
  assign w_unused_rdata = P_TIMEOUT_RDATA;
`endif

endmodule

// File: tb/tb_cmd_host_arbiter.sv
// Scoreboard bench for cmd_host_arbiter: stimulus queues expectations,
// a negedge monitor pops and checks every downstream sel and host ack.
module tb_cmd_host_arbiter;
  localparam int NH = 3;
  localparam int AW = 26;
  localparam int DW = 32;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dexp_t;

  typedef struct {
    int            host;
    logic [DW-1:0] rdata;
  } aexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  intf_cmd #(.AW(AW), .DW(DW)) host_if [NH-1:0] ();
  intf_cmd #(.AW(AW), .DW(DW)) down_if ();

  logic [NH-1:0] h_sel;
  logic [NH-1:0] h_rw;
  logic [NH-1:0] h_ack;
  logic [AW-1:0] h_addr  [NH];
  logic [DW-1:0] h_wdata [NH];
  logic [DW-1:0] h_rdata [NH];

  for (genvar h = 0; h < NH; h++) begin : g_h
    assign host_if[h].sel       = h_sel[h];
    assign host_if[h].rd_wr_n   = h_rw[h];
    assign host_if[h].byte_addr = h_addr[h];
    assign host_if[h].wdata     = h_wdata[h];
    assign h_ack[h]             = host_if[h].ack;
    assign h_rdata[h]           = host_if[h].rdata;
  end

  logic          d_ack;
  logic [DW-1:0] d_rdata;
  assign down_if.ack   = d_ack;
  assign down_if.rdata = d_rdata;

  logic [NH-1:0] req_drop;
  logic [15:0]   tcnt;

  cmd_host_arbiter #(
    .NUM_HOSTS(NH),
    .HOST_ADDRESS_BITS(AW),
    .HOST_DATA_BITS(DW),
    .P_CMD_ACK_TIMEOUT_CLKS(32),
    .P_TIMEOUT_RDATA(32'hDEAD_0ACC)
  ) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .i_cmd(host_if),
    .o_cmd(down_if),
    .o_req_drop(req_drop),
    .o_timeout_cnt(tcnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  dexp_t q_down [$];
  aexp_t q_ack  [$];

  int t_dsel = -1;
  int t_hack = -1;

  int            resp_dly   = 1;
  logic [DW-1:0] resp_rdata = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected output, expected none", nm);
  endtask

  // Monitor: every downstream sel and host ack must match the next queued entry.
  always @(negedge clk) begin : mon
    dexp_t e;
    aexp_t a;
    if (down_if.sel) begin
      t_dsel = cyc;
      if (q_down.size() == 0) begin
        bad("dsel_unexpected");
      end else begin
        e = q_down.pop_front();
        chk("dsel_fields",
            {down_if.rd_wr_n, down_if.byte_addr, down_if.wdata},
            {e.rw, e.addr, e.wdata});
      end
    end
    if (h_ack != '0) begin
      t_hack = cyc;
      chk("hack_onehot", 64'($onehot(h_ack)), 64'd1);
      if (q_ack.size() == 0) begin
        bad("hack_unexpected");
      end else begin
        a = q_ack.pop_front();
        chk("hack_host", h_ack, NH'(1) << a.host);
        chk("hack_rdata", h_rdata[a.host], a.rdata);
      end
    end
  end

  // Downstream target model: ack resp_dly cycles after sel, or never if negative.
  initial begin
    d_ack   = 1'b0;
    d_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (down_if.sel && resp_dly >= 0) begin
        repeat (resp_dly) begin
          @(posedge clk);
          #1;
        end
        d_ack   = 1'b1;
        d_rdata = resp_rdata;
        @(posedge clk);
        #1;
        d_ack = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) tick();
    @(negedge clk);
  endtask

  task automatic drv(int h, logic rw, logic [AW-1:0] a, logic [DW-1:0] d);
    h_sel[h]   = 1'b1;
    h_rw[h]    = rw;
    h_addr[h]  = a;
    h_wdata[h] = d;
  endtask

  task automatic exp_d(logic rw, logic [AW-1:0] a, logic [DW-1:0] d);
    dexp_t e;
    e.rw    = rw;
    e.addr  = a;
    e.wdata = d;
    q_down.push_back(e);
  endtask

  task automatic exp_a(int h, logic [DW-1:0] r);
    aexp_t a;
    a.host  = h;
    a.rdata = r;
    q_ack.push_back(a);
  endtask

  task automatic drain(string nm, int lim);
    int k = 0;
    while ((q_down.size() != 0 || q_ack.size() != 0) && k < lim) begin
      tick();
      k++;
    end
    chk(nm, 64'(q_down.size() + q_ack.size()), 64'd0);
    repeat (2) tick();
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_dsel"}, down_if.sel, 1'b0);
    chk({nm, "_drw"}, down_if.rd_wr_n, 1'b1);
    chk({nm, "_daddr"}, down_if.byte_addr, '0);
    chk({nm, "_dwdata"}, down_if.wdata, '0);
    chk({nm, "_hack"}, h_ack, '0);
    for (int h = 0; h < NH; h++)
      chk({nm, "_hrdata"}, h_rdata[h], '0);
    chk({nm, "_drop"}, req_drop, '0);
    chk({nm, "_tcnt"}, tcnt, '0);
  endtask

  initial begin
    int n0;
    int s0;
    int s2;
    h_sel = '0;
    h_rw  = '1;
    for (int h = 0; h < NH; h++) begin
      h_addr[h]  = '0;
      h_wdata[h] = '0;
    end

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk_reset("reset");
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Round robin: all three at once, twice, then hosts 0 and 2.
    resp_dly   = 1;
    resp_rdata = 32'h0000_0A0A;
    drv(0, 1'b1, 26'h10, 32'h0);
    drv(1, 1'b0, 26'h20, 32'h1111);
    drv(2, 1'b1, 26'h30, 32'h0);
    exp_d(1'b1, 26'h10, 32'h0);
    exp_d(1'b0, 26'h20, 32'h1111);
    exp_d(1'b1, 26'h30, 32'h0);
    exp_a(0, 32'h0000_0A0A);
    exp_a(1, 32'h0000_0A0A);
    exp_a(2, 32'h0000_0A0A);
    tick();
    h_sel = '0;
    drain("rr1_drain", 40);

    resp_rdata = 32'h0000_0B0B;
    drv(0, 1'b0, 26'h11, 32'h2220);
    drv(1, 1'b0, 26'h21, 32'h2221);
    drv(2, 1'b0, 26'h31, 32'h2222);
    exp_d(1'b0, 26'h11, 32'h2220);
    exp_d(1'b0, 26'h21, 32'h2221);
    exp_d(1'b0, 26'h31, 32'h2222);
    exp_a(0, 32'h0000_0B0B);
    exp_a(1, 32'h0000_0B0B);
    exp_a(2, 32'h0000_0B0B);
    tick();
    h_sel = '0;
    drain("rr2_drain", 40);

    resp_rdata = 32'h0000_0C0C;
    drv(0, 1'b1, 26'h12, 32'h0);
    drv(2, 1'b1, 26'h32, 32'h0);
    exp_d(1'b1, 26'h12, 32'h0);
    exp_d(1'b1, 26'h32, 32'h0);
    exp_a(0, 32'h0000_0C0C);
    exp_a(2, 32'h0000_0C0C);
    tick();
    h_sel = '0;
    drain("rr3_drain", 40);

    // Single read on host 1 with exact latencies.
    resp_dly   = 3;
    resp_rdata = 32'h1234_5678;
    n0 = cyc;
    drv(1, 1'b1, 26'h0100010, 32'h0);
    exp_d(1'b1, 26'h0100010, 32'h0);
    exp_a(1, 32'h1234_5678);
    tick();
    h_sel = '0;
    drain("sr_drain", 30);
    chk("sr_dsel_lat", 64'(t_dsel), 64'(n0 + 2));
    chk("sr_hack_lat", 64'(t_hack), 64'(n0 + 6));
    repeat (3) tick();
    @(negedge clk);
    chk("sr_rdata_hold", h_rdata[1], 32'h1234_5678);

    // Drop: second host0 sel while its first request is still pending.
    chk("drop_clear", req_drop, 3'b000);
    resp_dly   = 6;
    resp_rdata = 32'h0000_BEEF;
    drv(2, 1'b0, 26'h200, 32'hAAAA_0002);
    exp_d(1'b0, 26'h200, 32'hAAAA_0002);
    exp_a(2, 32'h0000_BEEF);
    tick();
    h_sel = '0;
    repeat (2) tick();
    drv(0, 1'b0, 26'h40, 32'h0000_AAAA);
    exp_d(1'b0, 26'h40, 32'h0000_AAAA);
    exp_a(0, 32'h0000_BEEF);
    tick();
    drv(0, 1'b0, 26'h44, 32'h0000_BBBB);
    tick();
    h_sel = '0;
    drain("drop_drain", 40);
    chk("drop_flag", req_drop, 3'b001);

    // Timeout, then an ack landing on the final timeout cycle.
    chk("to_cnt_zero", tcnt, 16'd0);
    resp_dly = -1;
    n0 = cyc;
    s0 = n0 + 2;
    s2 = s0 + 33;
    drv(0, 1'b1, 26'h300, 32'h0);
    exp_d(1'b1, 26'h300, 32'h0);
`ifdef CMD_ARB_TIMEOUT_RESP_EN
    exp_a(0, 32'hDEAD_0ACC);
`endif
    tick();
    h_sel = '0;
    while (cyc < s0 + 5) tick();
    resp_dly   = 31;
    resp_rdata = 32'hCAFE_F00D;
    drv(1, 1'b1, 26'h310, 32'h0);
    exp_d(1'b1, 26'h310, 32'h0);
    exp_a(1, 32'hCAFE_F00D);
    tick();
    h_sel = '0;
    wait_cyc(s0 + 31);
    chk("to_cnt_before", tcnt, 16'd0);
    wait_cyc(s0 + 32);
    chk("to_cnt_after", tcnt, 16'd1);
`ifdef CMD_ARB_TIMEOUT_RESP_EN
    chk("to_hack_lat", 64'(t_hack), 64'(s0 + 32));
`endif
    wait_cyc(s0 + 34);
    chk("to_idle_lat", 64'(t_dsel), 64'(s2));
    wait_cyc(s2 + 33);
    chk("late_ack_lat", 64'(t_hack), 64'(s2 + 32));
    chk("late_ack_tcnt", tcnt, 16'd1);
    drain("to_drain", 10);

    // Reset while waiting for an ack with hosts 1 and 2 pending.
    resp_dly = -1;
    n0 = cyc;
    s0 = n0 + 2;
    drv(0, 1'b1, 26'h400, 32'h0);
    exp_d(1'b1, 26'h400, 32'h0);
    tick();
    h_sel = '0;
    while (cyc < s0 + 1) tick();
    drv(1, 1'b1, 26'h410, 32'h0);
    drv(2, 1'b0, 26'h420, 32'h4242);
    tick();
    h_sel = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_down.delete();
    q_ack.delete();
    @(negedge clk);
    chk_reset("rst_mid");
    repeat (40) tick();
    chk("rst_no_dsel", 64'(t_dsel), 64'(s0));
    resp_dly   = 1;
    resp_rdata = 32'h0000_5555;
    drv(2, 1'b0, 26'h500, 32'h0000_0005);
    exp_d(1'b0, 26'h500, 32'h0000_0005);
    exp_a(2, 32'h0000_5555);
    tick();
    h_sel = '0;
    drain("post_rst_drain", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
